serial_lookahead_subtractor: RTL and testbench

//  Digit-serial WIDTH-bit subtractor: computes diff = a - b one 4-bit digit per cycle, LSB digit first.

---
 rtl/serial_lookahead_subtractor_pkg.sv | 9 +
 rtl/serial_lookahead_subtractor_borrow.sv | 15 +
 rtl/serial_lookahead_subtractor.sv | 119 +++++++++++
 tb/tb_serial_lookahead_subtractor.sv | 124 ++++++++++++
 4 files changed

// File: rtl/serial_lookahead_subtractor_pkg.sv
// serial_lookahead_subtractor_pkg: FSM state encodings and digit width shared by the subtractor.
package serial_lookahead_subtractor_pkg;
    localparam int DIGIT_W = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_lookahead_subtractor_borrow.sv
// lookahead_borrow_unit: two-level sum-of-products borrow lookahead across one 4-bit digit.
module lookahead_borrow_unit (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       bin,
    output logic [3:0] br,
    output logic       bout
);
    assign br[0] = bin;
    assign br[1] = g[0] | (p[0] & bin);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
    assign bout  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & bin);
endmodule

// File: rtl/serial_lookahead_subtractor.sv
// serial_lookahead_subtractor: digit-serial a-b, one 4-bit digit per cycle, LSB digit first.
module serial_lookahead_subtractor
    import serial_lookahead_subtractor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int CW   = $clog2(NDIG);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic             br_q, br_d, bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
    logic [3:0]       g, p, br, dig;
    logic             dbout;

    assign g   = ~a_q[3:0] & b_q[3:0];
    assign p   = ~(a_q[3:0] ^ b_q[3:0]);
    assign dig = a_q[3:0] ^ b_q[3:0] ^ br;

    lookahead_borrow_unit u_lbu (
        .g   (g),
        .p   (p),
        .bin (br_q),
        .br  (br),
        .bout(dbout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        case (state_q)
            RUN: begin
                a_d    = a_q >> DIGIT_W;
                b_d    = b_q >> DIGIT_W;
                diff_d = {dig, diff_q[WIDTH-1:DIGIT_W]};
                br_d   = dbout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d = DONE;
                    bout_d  = dbout;
                    ovf_d   = (amsb_q ^ bmsb_q) & (amsb_q ^ dig[3]);
                    zero_d  = diff_d == '0;
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
        end
    end

    assign ready = state_q == IDLE || state_q == DONE;
    assign busy  = state_q == RUN;
    assign done  = state_q == DONE;
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;
endmodule

// File: tb/tb_serial_lookahead_subtractor.sv
// tb_serial_lookahead_subtractor: scoreboard bench; driver queues expected results, monitor checks on done.
module tb_serial_lookahead_subtractor;
    logic        clk = 0, rst = 1, start = 0;
    logic [31:0] a = 0, b = 0, diff;
    logic        ready, busy, done, bout, ovf, zero;
    int          cyc = 0, checks = 0, passes = 0;

    typedef struct {
        logic [31:0] d;
        logic        bo, ov, z;
        int          c;
    } exp_t;
    exp_t q[$];

    serial_lookahead_subtractor #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ed,
                        input logic eb, input logic eo, input logic ez);
        exp_t e;
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
        a = x;
        b = y;
        start = 1;
        e.d = ed; e.bo = eb; e.ov = eo; e.z = ez; e.c = cyc + 9;
        q.push_back(e);
        @(negedge clk);
        start = 0;
    endtask

    task automatic send_rand(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        d = x - y;
        send(x, y, d, x < y, (x[31] ^ y[31]) & (x[31] ^ d[31]), d == 0);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", diff, e.d);
                chk("bout", {31'b0, bout}, {31'b0, e.bo});
                chk("ovf", {31'b0, ovf}, {31'b0, e.ov});
                chk("zero", {31'b0, zero}, {31'b0, e.z});
                chk("done_cycle", cyc, e.c);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_ready", {31'b0, ready}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_diff", diff, 0);
        chk("rst_flags", {29'b0, bout, ovf, zero}, 0);
        @(negedge clk);
        send(32'h00000005, 32'h00000003, 32'h00000002, 0, 0, 0);
        send(32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1, 0, 0);
        send(32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 0);
        send(32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 1, 0);
        send(32'h12345678, 32'h12345678, 32'h00000000, 0, 0, 1);
        send(32'h00010000, 32'h00000001, 32'h0000FFFF, 0, 0, 0);
        drain();
        send(32'h00000100, 32'h00000011, 32'h000000EF, 0, 0, 0);
        @(negedge clk);
        a = 32'hDEADBEEF;
        b = 32'h00000001;
        start = 1;
        @(negedge clk);
        start = 0;
        a = 32'h0;
        drain();
        a = 32'h55555555;
        b = 32'h11111111;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_ready", {31'b0, ready}, 1);
        chk("abort_diff", diff, 0);
        chk("abort_flags", {29'b0, bout, ovf, zero}, 0);
        repeat (15) @(negedge clk);
        send(32'h00000010, 32'h00000020, 32'hFFFFFFF0, 1, 0, 0);
        send(32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0);
        for (int i = 0; i < 1000; i++) send_rand($urandom, $urandom);
        drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
